// File: rtl/gates7_selftest_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gates7_pkg
// Brief    : Shared types, bit indices, vector order and golden truth table
//            for the seven-function gate self-test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package gates7_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef logic [6:0] fvec_t;
    typedef logic [2:0] ecnt_t;

    localparam int F_AND  = 6;
    localparam int F_OR   = 5;
    localparam int F_NOT  = 4;
    localparam int F_NAND = 3;
    localparam int F_NOR  = 2;
    localparam int F_XOR  = 1;
    localparam int F_XNOR = 0;

    // {a,b} per step, step 0 in the low bits: 00, 10, 01, 11
    localparam logic [7:0] VEC_ORDER = {2'b11, 2'b01, 2'b10, 2'b00};

    function automatic logic [1:0] vec_at(input logic [1:0] idx);
        return VEC_ORDER[{idx, 1'b0} +: 2];
    endfunction

    function automatic fvec_t gates7_expect(input logic a, input logic b);
        fvec_t e;
        e         = '0;
        e[F_AND]  = a & b;
        e[F_OR]   = a | b;
        e[F_NOT]  = ~a;
        e[F_NAND] = ~(a & b);
        e[F_NOR]  = ~(a | b);
        e[F_XOR]  = a ^ b;
        e[F_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gates7_selftest_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gates7_selftest_ctrl_if
// Brief    : Control, status and gate-unit bus of the self-test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface gates7_selftest_ctrl_if;
    import gates7_pkg::*;

    logic        start;
    logic [1:0]  ab;
    fvec_t       f;
    logic        busy;
    logic        done;
    logic        pass;
    ecnt_t       err_cnt;
    fvec_t       fail_vec;

    modport master (
        input  start,
        input  f,
        output ab,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_vec
    );

    modport slave (
        output start,
        output f,
        input  ab,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_vec
    );

endinterface
`default_nettype wire

// File: rtl/gates7_selftest_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module   : gates7_selftest_cnt
// Brief    : Settle-wait down-counter with synchronous load and zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module gates7_selftest_cnt (
    input  wire logic       clk,
    input  wire logic       clrn,
    input  wire logic       load_i,
    input  wire logic [3:0] load_val_i,
    input  wire logic       dec_i,
    output logic            zero_o
);
    import gates7_pkg::*;

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/gates7_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gates7_selftest_ctrl
// Brief    : Drives the four {a,b} vectors into the gate unit, checks the
//            seven outputs against the golden table and reports results.
// Revision : 1.0 - initial release
// ============================================================================
module gates7_selftest_ctrl #(
    parameter int SETTLE = 1
) (
    input  wire logic               clk,
    input  wire logic               clrn,
    gates7_selftest_ctrl_if.master  bus
);
    import gates7_pkg::*;

    // Counter is loaded in DRIVE so WAIT lasts exactly SETTLE cycles
    localparam logic [3:0] LOAD_VAL = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [1:0]  ab_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    ecnt_t       err_q;
    fvec_t       fail_q;

    fvec_t       mism;
    ecnt_t       err_d;
    logic        cnt_zero;
    logic        cnt_load;
    logic        cnt_dec;

    assign mism     = bus.f ^ gates7_expect(ab_q[1], ab_q[0]);
    assign err_d    = err_q + ((mism != '0) ? 3'd1 : 3'd0);
    assign cnt_load = (state_q == ST_DRIVE);
    assign cnt_dec  = (state_q == ST_WAIT);

    gates7_selftest_cnt u_cnt (
        .clk        (clk),
        .clrn       (clrn),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_DRIVE;
                        idx_q   <= 2'd0;
                        ab_q    <= vec_at(2'd0);
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= '0;
                    end
                end
                ST_DRIVE: begin
                    state_q <= (SETTLE > 0) ? ST_WAIT : ST_CHECK;
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    fail_q <= fail_q | mism;
                    err_q  <= err_d;
                    if (idx_q == 2'd3) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_d == '0);
                        ab_q    <= 2'b00;
                    end else begin
                        state_q <= ST_DRIVE;
                        idx_q   <= idx_q + 2'd1;
                        ab_q    <= vec_at(idx_q + 2'd1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ab       = ab_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gates7_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gates7_selftest_ctrl
// Brief    : Self-checking bench: three sequencers (SETTLE 0/1/15) each
//            driving a faultable gate-unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gates7_selftest_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic [2:0]  st;
    logic [6:0]  s0;
    logic [6:0]  inv;
    logic [27:0] rmask;

    int checks = 0;
    int errors = 0;
    int dc [3];
    int nd [3];
    int exp_dc [3] = '{9, 13, 69};

    always #5 clk = ~clk;

    // Truth table from arithmetic on 0/1 integers: {and,or,not,nand,nor,xor,xnor}
    function automatic logic [6:0] golden(input logic [1:0] abv);
        int a, b, x_and, x_or, x_xor;
        a     = int'(abv[1]);
        b     = int'(abv[0]);
        x_and = a * b;
        x_or  = a + b - a * b;
        x_xor = (a + b) % 2;
        return {1'(x_and), 1'(x_or), 1'(1 - a), 1'(1 - x_and),
                1'(1 - x_or), 1'(x_xor), 1'(1 - x_xor)};
    endfunction

    function automatic logic [6:0] faulty(input logic [1:0] abv, input logic [6:0] stuck0,
                                          input logic [6:0] flip, input logic [27:0] rm);
        return ((golden(abv) & ~stuck0) ^ flip) ^ rm[int'(abv) * 7 +: 7];
    endfunction

    gates7_selftest_ctrl_if if0 ();
    gates7_selftest_ctrl_if if1 ();
    gates7_selftest_ctrl_if if15 ();

    assign if0.start  = st[0];
    assign if1.start  = st[1];
    assign if15.start = st[2];
    assign if0.f      = faulty(if0.ab,  s0, inv, rmask);
    assign if1.f      = faulty(if1.ab,  s0, inv, rmask);
    assign if15.f     = faulty(if15.ab, s0, inv, rmask);

    gates7_selftest_ctrl #(.SETTLE(0))  u_dut0  (.clk(clk), .clrn(clrn), .bus(if0.master));
    gates7_selftest_ctrl #(.SETTLE(1))  u_dut1  (.clk(clk), .clrn(clrn), .bus(if1.master));
    gates7_selftest_ctrl #(.SETTLE(15)) u_dut15 (.clk(clk), .clrn(clrn), .bus(if15.master));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-run outcome from the fault model, independent of vector order
    task automatic model(output logic ep, output logic [2:0] ee, output logic [6:0] efv);
        logic [6:0] m;
        ee  = 3'd0;
        efv = 7'd0;
        for (int v = 0; v < 4; v++) begin
            m   = faulty(2'(v), s0, inv, rmask) ^ golden(2'(v));
            efv = efv | m;
            if (m != 7'd0) ee = ee + 3'd1;
        end
        ep = (ee == 3'd0);
    endtask

    task automatic obs(input string tag, input int i, input int k,
                       input logic d, input logic b, input logic p,
                       input logic [2:0] e, input logic [6:0] fv,
                       input logic ep, input logic [2:0] ee, input logic [6:0] efv);
        if (k == 1) chk($sformatf("%s busy_c1[%0d]", tag, i), 32'(b), 32'd1);
        if (d) begin
            nd[i]++;
            if (dc[i] < 0) begin
                dc[i] = k;
                chk($sformatf("%s busy_done[%0d]", tag, i), 32'(b), 32'd0);
                chk($sformatf("%s pass[%0d]", tag, i), 32'(p), 32'(ep));
                chk($sformatf("%s err_cnt[%0d]", tag, i), 32'(e), 32'(ee));
                chk($sformatf("%s fail_vec[%0d]", tag, i), 32'(fv), 32'(efv));
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] en, input bit glitch,
                       input logic ep, input logic [2:0] ee, input logic [6:0] efv);
        logic [7:0] abseq;
        abseq = 8'h00;
        for (int i = 0; i < 3; i++) begin dc[i] = -1; nd[i] = 0; end
        @(negedge clk); st = en;
        @(negedge clk); st = 3'b000;
        for (int k = 1; k <= 72; k++) begin
            if (k > 1) @(negedge clk);
            if (en[1] && (k == 1 || k == 4 || k == 7 || k == 10))
                abseq = {if1.ab, abseq[7:2]};
            if (en[0]) obs(tag, 0, k, if0.done,  if0.busy,  if0.pass,  if0.err_cnt,  if0.fail_vec,  ep, ee, efv);
            if (en[1]) obs(tag, 1, k, if1.done,  if1.busy,  if1.pass,  if1.err_cnt,  if1.fail_vec,  ep, ee, efv);
            if (en[2]) obs(tag, 2, k, if15.done, if15.busy, if15.pass, if15.err_cnt, if15.fail_vec, ep, ee, efv);
            st = 3'b000;
            if (glitch) st[1] = (k == 3 || k == 7 || k == 13);
        end
        if (en[1]) chk({tag, " ab_order"}, 32'(abseq), 32'({2'b11, 2'b01, 2'b10, 2'b00}));
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                chk($sformatf("%s done_cycle[%0d]", tag, i), 32'(dc[i]), 32'(exp_dc[i]));
                chk($sformatf("%s done_pulses[%0d]", tag, i), 32'(nd[i]), 32'd1);
            end
        end
        if (en[1]) begin
            chk({tag, " held_pass"}, 32'(if1.pass), 32'(ep));
            chk({tag, " held_err"},  32'(if1.err_cnt), 32'(ee));
            chk({tag, " held_fail"}, 32'(if1.fail_vec), 32'(efv));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ab"},       32'(if1.ab), 32'd0);
        chk({tag, " busy"},     32'(if1.busy), 32'd0);
        chk({tag, " done"},     32'(if1.done), 32'd0);
        chk({tag, " pass"},     32'(if1.pass), 32'd0);
        chk({tag, " err_cnt"},  32'(if1.err_cnt), 32'd0);
        chk({tag, " fail_vec"}, 32'(if1.fail_vec), 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [6:0] s0;
        logic [6:0] inv;
        logic       ep;
        logic [2:0] ee;
        logic [6:0] efv;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic       mp;
        logic [2:0] me;
        logic [6:0] mf;

        tbl[0] = '{"fault_free",  7'h00, 7'h00, 1'b1, 3'd0, 7'h00};
        tbl[1] = '{"xor_sa0",     7'h02, 7'h00, 1'b0, 3'd2, 7'h02};
        tbl[2] = '{"not_inv",     7'h00, 7'h10, 1'b0, 3'd4, 7'h10};
        tbl[3] = '{"fault_free2", 7'h00, 7'h00, 1'b1, 3'd0, 7'h00};

        clrn  = 1'b0;
        st    = 3'b000;
        s0    = 7'h00;
        inv   = 7'h00;
        rmask = 28'h0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        clrn = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_reset");

        for (int t = 0; t < 4; t++) begin
            s0    = tbl[t].s0;
            inv   = tbl[t].inv;
            rmask = 28'h0;
            run(tbl[t].name, 3'b111, 1'b0, tbl[t].ep, tbl[t].ee, tbl[t].efv);
        end

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                s0 = 7'h00; inv = 7'h00; rmask = 28'h0;
            end else begin
                s0    = 7'($urandom) & 7'($urandom) & 7'($urandom);
                inv   = 7'($urandom) & 7'($urandom) & 7'($urandom) & 7'($urandom);
                rmask = 28'($urandom) & 28'($urandom) & 28'($urandom);
            end
            model(mp, me, mf);
            run($sformatf("rand%0d", r), 3'b111, 1'b0, mp, me, mf);
        end

        s0 = 7'h00; inv = 7'h00; rmask = 28'h0;
        run("start_glitch", 3'b010, 1'b1, 1'b1, 3'd0, 7'h00);

        // Abort mid-run with two mismatches already accumulated
        rmask = 28'h0;
        rmask[0 +: 7]  = 7'h01;
        rmask[14 +: 7] = 7'h40;
        @(negedge clk); st = 3'b010;
        @(negedge clk); st = 3'b000;
        repeat (7) @(negedge clk);
        chk("pre_abort busy", 32'(if1.busy), 32'd1);
        chk("pre_abort err_cnt", 32'(if1.err_cnt), 32'd2);
        #2 clrn = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        clrn = 1'b1;
        model(mp, me, mf);
        run("post_abort", 3'b111, 1'b0, mp, me, mf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gates7_selftest_ctrl.md
# gates7_selftest_ctrl

Self-test sequencer for the seven-function two-input gate unit (and, or, not, nand, nor, xor, xnor). On `start` it drives the unit's `a`/`b` inputs through all four input combinations and waits a programmable settle time after each. It then samples the seven outputs, compares them against a golden truth table, and reports pass/fail, a per-function failure mask and a mismatch count. It replaces hand-written stimulus benches for on-chip checking of the gate datapath.

## Interface
- `SETTLE`, default 1: wait cycles between driving a vector and sampling outputs; legal range 0..15.
- `clk` in 1: clock, rising edge.
- `clrn` in 1: asynchronous active-low reset.
- `start` in 1: begin a test run; sampled only in IDLE.
- `ab` out 2: `{a,b}` driven to the gate unit; registered.
- `f` in 7: gate outputs `{and,or,not,nand,nor,xor,xnor}`, bit 6 = and, bit 0 = xnor.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse when a run completes.
- `pass` out 1: 1 if the last run had zero mismatches; held until the next accepted start.
- `err_cnt` out 3: number of vectors (0..4) with any mismatch in the last run.
- `fail_vec` out 7: OR of per-bit mismatches across the last run, same bit order as `f`.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE:
  - `start`=1 moves to DRIVE.
  - On acceptance, clear vector index, `err_cnt`, `fail_vec` and `pass`.
- DRIVE: `ab` = vector[idx]. The vector order is 00, 10, 01, 11 (written as `{a,b}`).
  - Go to WAIT if `SETTLE`>0, otherwise go to CHECK.
- WAIT:
  - The settle counter counts `SETTLE` cycles.
  - `ab` is held during the count.
  - Go to CHECK after the last count.
- CHECK: sample `f` and compute `mism = f ^ expect(ab)`.
  - Expected functions: and=a&b, or=a|b, not=~a, nand, nor, xor, xnor.
  - `fail_vec |= mism`.
  - If `mism != 0`, increment `err_cnt`.
  - If idx = 3, go to DONE. Otherwise increment idx and go to DRIVE.
- DONE:
  - `done`=1 for this cycle.
  - `pass` = (`err_cnt`==0 including this run's final vector).
  - `ab` returns to 00.
  - Go to IDLE.
- `busy` = 1 in DRIVE, WAIT and CHECK; 0 in IDLE and DONE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- `err_cnt` never exceeds 4, so no saturation logic is needed.
- Results (`pass`, `err_cnt`, `fail_vec`) are held unchanged in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, `ab`=00, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, idx=0.
- Reset is asynchronous. Assertion at any point, including mid-run, forces these values immediately; no partial results survive.
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: first DRIVE; `ab`=00 is visible from this cycle.
- Each vector occupies `SETTLE`+2 cycles (DRIVE, `SETTLE`×WAIT, CHECK).
- `done` is high in cycle 4·(`SETTLE`+2)+1. This is cycle 13 for `SETTLE`=1 and cycle 9 for `SETTLE`=0.
- `f` is sampled in CHECK at least `SETTLE`+1 edges after `ab` changed. The gate unit is combinational, so `SETTLE`=0 is functionally correct in RTL.
- Back-to-back runs: `start` held high continuously gives a new run accepted in the IDLE cycle following DONE. That is a minimum 1-cycle gap with `busy`=0.

## Structure
- Package `gates7_pkg` holds:
  - state enum;
  - bit-index constants `F_AND`=6 .. `F_XNOR`=0;
  - the four-entry vector-order constant;
  - function `gates7_expect(a,b)` returning the 7-bit golden vector.
- Sub-module `gates7_selftest_cnt`: the settle-wait down-counter, with load and zero flag.
- Everything else is one FSM plus result registers in the top module.

## Test plan
- Fault-free gate unit, `SETTLE`=1, pulse `start`:
  - `ab` steps 00, 10, 01, 11.
  - `done` appears at cycle 13 with `pass`=1, `err_cnt`=0, `fail_vec`=0000000.
- Xor output stuck at 0:
  - `pass`=0, `err_cnt`=2, `fail_vec`=0000010.
- Not output inverted:
  - `err_cnt`=4, `fail_vec`=0010000.
  - A second run with a fault-free unit gives `pass`=1 and clears the previous results.
- `start` pulsed at cycles 3, 7 and in the DONE cycle:
  - Exactly one run occurs.
  - `done` stays a single pulse.
- `clrn` asserted during the WAIT of vector 2:
  - All outputs go to reset values immediately.
  - A following `start` runs the full 4-vector sequence from 00.
- `SETTLE`=0 and `SETTLE`=15:
  - `done` appears at cycles 9 and 69 respectively.
  - Results are identical to the `SETTLE`=1 run.
